// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - BTB plus gshare/bimodal saturating-counter branch predictor
module branch_predictor_gshare #(
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2,
  parameter int GHR_BITS = 4,
  parameter int GSHARE   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                lookup_valid_i,
  input  logic [31:0]         pc_i,
  output logic                pred_valid_o,
  output logic                pred_hit_o,
  output logic                pred_taken_o,
  output logic [31:0]         pred_pc_o,
  output logic [GHR_BITS-1:0] pred_ghr_o,
  input  logic                resolve_valid_i,
  input  logic [31:0]         resolve_pc_i,
  input  logic [31:0]         resolve_target_i,
  input  logic                resolve_is_branch_i,
  input  logic                resolve_taken_i,
  input  logic                resolve_pred_taken_i,
  input  logic [31:0]         resolve_pred_pc_i,
  input  logic [GHR_BITS-1:0] resolve_ghr_i,
  output logic                mispredict_o,
  output logic                busy_o
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);
  localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX     = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_MIN     = '0;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t               state_q, state_d;
  logic [IDX_BITS-1:0]  clr_idx_q, clr_idx_d;
  logic [GHR_BITS-1:0]  ghr_q, ghr_d;

  // Table storage; CLEAR initialises valid and counters, tag/target are only
  // meaningful once valid is set.
  logic                 valid_q [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q   [ENTRIES];
  logic [31:0]          tgt_q   [ENTRIES];
  logic [CNT_BITS-1:0]  cnt_q   [ENTRIES];

  // Lookup-side decode
  logic [IDX_BITS-1:0]  lk_idx;
  logic [TAG_BITS-1:0]  lk_tag;
  logic [IDX_BITS-1:0]  lk_ghr_ext;
  logic [IDX_BITS-1:0]  lk_cidx;
  logic                 lk_hit;
  logic                 lk_taken;

  // Resolve-side decode
  logic [IDX_BITS-1:0]  rs_idx;
  logic [TAG_BITS-1:0]  rs_tag;
  logic [IDX_BITS-1:0]  rs_ghr_ext;
  logic [IDX_BITS-1:0]  rs_cidx;
  logic                 rs_hit;
  logic [CNT_BITS-1:0]  rs_cnt;
  logic [CNT_BITS-1:0]  rs_cnt_next;

  logic                 restart;
  logic                 upd_en;
  logic                 br_upd;
  logic                 hit_upd;
  logic                 alloc_upd;
  logic                 inval_upd;
  logic                 unused_bits;

  assign restart     = rst_i | flush_i;
  assign unused_bits = ^{pc_i[1:0], resolve_pc_i[1:0]};

  // Lookup index/tag extraction and the history-hashed counter index
  always_comb begin
    lk_idx = pc_i[IDX_BITS+1:2];
    lk_tag = pc_i[31:IDX_BITS+2];
    lk_ghr_ext = '0;
    lk_ghr_ext[GHR_BITS-1:0] = ghr_q;
    lk_cidx  = (GSHARE != 0) ? (lk_idx ^ lk_ghr_ext) : lk_idx;
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && cnt_q[lk_cidx][CNT_BITS-1];
  end

  // Resolve decode; the counter index uses the history carried with the
  // instruction so training lands on the counter that made the prediction
  always_comb begin
    rs_idx = resolve_pc_i[IDX_BITS+1:2];
    rs_tag = resolve_pc_i[31:IDX_BITS+2];
    rs_ghr_ext = '0;
    rs_ghr_ext[GHR_BITS-1:0] = resolve_ghr_i;
    rs_cidx = (GSHARE != 0) ? (rs_idx ^ rs_ghr_ext) : rs_idx;
    rs_hit  = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
    rs_cnt  = cnt_q[rs_cidx];
    rs_cnt_next = rs_cnt;
    if (resolve_taken_i) begin
      if (rs_cnt != CNT_MAX) rs_cnt_next = rs_cnt + CNT_BITS'(1);
    end else begin
      if (rs_cnt != CNT_MIN) rs_cnt_next = rs_cnt - CNT_BITS'(1);
    end
  end

  // Update qualification: training is suppressed while the table is clearing
  always_comb begin
    upd_en    = resolve_valid_i && (state_q == ST_READY) && !restart;
    br_upd    = upd_en && resolve_is_branch_i;
    hit_upd   = br_upd && rs_hit;
    alloc_upd = br_upd && !rs_hit && resolve_taken_i;
    inval_upd = upd_en && !resolve_is_branch_i && resolve_pred_taken_i;
  end

  // Combinational mispredict flag, independent of the FSM state
  always_comb begin
    mispredict_o = resolve_valid_i &&
                   ((resolve_taken_i != resolve_pred_taken_i) ||
                    (resolve_taken_i && (resolve_pred_pc_i != resolve_target_i)) ||
                    (!resolve_is_branch_i && resolve_pred_taken_i));
  end

  // FSM state register with clear-index counter
  always_ff @(posedge clk_i) begin
    if (restart) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // FSM next state: CLEAR walks every entry once, then READY
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_BITS'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_READY;
          clr_idx_d = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q == ST_CLEAR);
  end

  // Non-speculative global history: shifts only on resolved branches
  always_comb begin
    ghr_d = ghr_q;
    if (br_upd) ghr_d = GHR_BITS'({ghr_q, resolve_taken_i});
  end

  // History register
  always_ff @(posedge clk_i) begin
    if (restart) ghr_q <= '0;
    else         ghr_q <= ghr_d;
  end

  // Table writes: clearing sweep, or training/allocation/invalidation when ready
  always_ff @(posedge clk_i) begin
    if (!restart) begin
      if (state_q == ST_CLEAR) begin
        valid_q[clr_idx_q] <= 1'b0;
        cnt_q[clr_idx_q]   <= CNT_WEAK_NT;
      end else begin
        if (hit_upd) begin
          cnt_q[rs_cidx] <= rs_cnt_next;
          if (resolve_taken_i) tgt_q[rs_idx] <= resolve_target_i;
        end
        if (alloc_upd) begin
          valid_q[rs_idx] <= 1'b1;
          tag_q[rs_idx]   <= rs_tag;
          tgt_q[rs_idx]   <= resolve_target_i;
          cnt_q[rs_cidx]  <= CNT_WEAK_T;
        end
        if (inval_upd) valid_q[rs_idx] <= 1'b0;
      end
    end
  end

  // Registered lookup result; reads pre-update table contents, holds when idle
  always_ff @(posedge clk_i) begin
    if (restart) begin
      pred_valid_o <= 1'b0;
      pred_hit_o   <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_pc_o    <= '0;
      pred_ghr_o   <= '0;
    end else if (lookup_valid_i) begin
      pred_valid_o <= 1'b1;
      pred_ghr_o   <= ghr_q;
      if (state_q == ST_READY) begin
        pred_hit_o   <= lk_hit;
        pred_taken_o <= lk_taken;
        pred_pc_o    <= lk_hit ? tgt_q[lk_idx] : 32'h0;
      end else begin
        pred_hit_o   <= 1'b0;
        pred_taken_o <= 1'b0;
        pred_pc_o    <= 32'h0;
      end
    end else begin
      pred_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - scoreboard bench with behavioural predictor model
module tb_branch_predictor_gshare;

  localparam int ENTRIES  = 16;
  localparam int CNT_BITS = 2;
  localparam int GHR_BITS = 4;
  localparam int GSHARE   = 1;
  localparam int IDX_BITS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_i = 1'b0, flush_i = 1'b0, lookup_valid_i = 1'b0;
  logic [31:0]         pc_i = '0;
  logic                pred_valid_o, pred_hit_o, pred_taken_o;
  logic [31:0]         pred_pc_o;
  logic [GHR_BITS-1:0] pred_ghr_o;
  logic                resolve_valid_i = 1'b0;
  logic [31:0]         resolve_pc_i = '0, resolve_target_i = '0, resolve_pred_pc_i = '0;
  logic                resolve_is_branch_i = 1'b0, resolve_taken_i = 1'b0, resolve_pred_taken_i = 1'b0;
  logic [GHR_BITS-1:0] resolve_ghr_i = '0;
  logic                mispredict_o, busy_o;

  branch_predictor_gshare #(.ENTRIES(ENTRIES), .CNT_BITS(CNT_BITS), .GHR_BITS(GHR_BITS), .GSHARE(GSHARE)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .lookup_valid_i(lookup_valid_i), .pc_i(pc_i),
    .pred_valid_o(pred_valid_o), .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o),
    .pred_pc_o(pred_pc_o), .pred_ghr_o(pred_ghr_o),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i), .resolve_target_i(resolve_target_i),
    .resolve_is_branch_i(resolve_is_branch_i), .resolve_taken_i(resolve_taken_i),
    .resolve_pred_taken_i(resolve_pred_taken_i), .resolve_pred_pc_i(resolve_pred_pc_i),
    .resolve_ghr_i(resolve_ghr_i), .mispredict_o(mispredict_o), .busy_o(busy_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  int          m_ghr = 0;
  int          m_clear_left = 0;
  bit          m_known = 0;

  typedef struct {
    bit          hit;
    bit          taken;
    logic [31:0] pc;
    int          ghr;
  } exp_t;
  exp_t expq[$];

  // Drive values, copied onto the DUT at the next falling edge
  bit          d_rst, d_flush, d_lv, d_rv, d_isb, d_tk, d_pt;
  logic [31:0] d_pc, d_rpc, d_rtgt, d_ppc;
  int          d_rghr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc >> (IDX_BITS + 2));
  endfunction

  function automatic int cidx_of(input logic [31:0] pc, input int ghr);
    return GSHARE ? (idx_of(pc) ^ ghr) : idx_of(pc);
  endfunction

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t e;
    int i;
    i = idx_of(pc);
    e.ghr = m_ghr;
    if (m_clear_left > 0) begin
      e.hit = 0; e.taken = 0; e.pc = 0;
    end else begin
      e.hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
      e.taken = e.hit && (m_cnt[cidx_of(pc, m_ghr)] >= (1 << (CNT_BITS - 1)));
      e.pc    = e.hit ? m_tgt[i] : 32'h0;
    end
    return e;
  endfunction

  task automatic model_update();
    int i, c;
    bit hit;
    if (d_rst || d_flush) begin
      m_clear_left = ENTRIES;
      m_ghr = 0;
      m_known = 1;
      return;
    end
    if (m_clear_left > 0) begin
      i = ENTRIES - m_clear_left;
      m_valid[i] = 0;
      m_cnt[i] = (1 << (CNT_BITS - 1)) - 1;
      m_clear_left--;
      return;
    end
    if (!d_rv) return;
    i = idx_of(d_rpc);
    c = cidx_of(d_rpc, d_rghr);
    if (d_isb) begin
      hit = m_valid[i] && (m_tag[i] == tag_of(d_rpc));
      if (hit) begin
        if (d_tk) begin
          if (m_cnt[c] < (1 << CNT_BITS) - 1) m_cnt[c]++;
          m_tgt[i] = d_rtgt;
        end else if (m_cnt[c] > 0) begin
          m_cnt[c]--;
        end
      end else if (d_tk) begin
        m_valid[i] = 1;
        m_tag[i] = tag_of(d_rpc);
        m_tgt[i] = d_rtgt;
        m_cnt[c] = 1 << (CNT_BITS - 1);
      end
      m_ghr = ((m_ghr << 1) | int'(d_tk)) % (1 << GHR_BITS);
    end else if (d_pt) begin
      m_valid[i] = 0;
    end
  endtask

  // One clock cycle: apply drive values, check combinational outputs, advance the model
  task automatic step();
    bit exp_mis;
    @(negedge clk);
    rst_i = d_rst; flush_i = d_flush; lookup_valid_i = d_lv; pc_i = d_pc;
    resolve_valid_i = d_rv; resolve_pc_i = d_rpc; resolve_target_i = d_rtgt;
    resolve_is_branch_i = d_isb; resolve_taken_i = d_tk; resolve_pred_taken_i = d_pt;
    resolve_pred_pc_i = d_ppc; resolve_ghr_i = GHR_BITS'(d_rghr);
    #1;
    exp_mis = d_rv && ((d_tk != d_pt) || (d_tk && d_ppc != d_rtgt) || (!d_isb && d_pt));
    chk("mispredict", 32'(mispredict_o), 32'(exp_mis));
    if (m_known) chk("busy", 32'(busy_o), 32'(m_clear_left > 0));
    if (d_lv && !d_rst && !d_flush && m_known) expq.push_back(model_lookup(d_pc));
    model_update();
  endtask

  task automatic idle();
    d_rst = 0; d_flush = 0; d_lv = 0; d_rv = 0; d_isb = 0; d_tk = 0; d_pt = 0;
    d_pc = 0; d_rpc = 0; d_rtgt = 0; d_ppc = 0; d_rghr = 0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    idle(); d_lv = 1; d_pc = pc; step(); idle();
  endtask

  task automatic do_resolve(input logic [31:0] pc, input logic [31:0] tgt, input bit isb,
                            input bit tk, input bit pt, input logic [31:0] ppc, input int ghr);
    idle();
    d_rv = 1; d_rpc = pc; d_rtgt = tgt; d_isb = isb; d_tk = tk; d_pt = pt; d_ppc = ppc; d_rghr = ghr;
    step();
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_tgt();
    return 32'h0000_1000 + 32'($urandom_range(0, 3) * 32'h40);
  endfunction

  // Monitor: every presented prediction must match the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (pred_valid_o === 1'b1) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pred_unexpected: pred_valid_o=1 with no lookup outstanding");
      end else begin
        e = expq.pop_front();
        checks++;
        if (pred_hit_o !== e.hit || pred_taken_o !== e.taken || pred_pc_o !== e.pc ||
            pred_ghr_o !== GHR_BITS'(e.ghr)) begin
          errors++;
          $display("FAIL pred: got hit=%b taken=%b pc=%h ghr=%h expected hit=%b taken=%b pc=%h ghr=%h",
                   pred_hit_o, pred_taken_o, pred_pc_o, pred_ghr_o, e.hit, e.taken, e.pc, e.ghr);
        end
      end
    end else if (expq.size() != 0) begin
      checks++; errors++;
      void'(expq.pop_front());
      $display("FAIL pred_missing: pred_valid_o=%b with a lookup outstanding", pred_valid_o);
    end
  end

  initial begin
    int busy_cnt;
    idle();
    // Reset and reset-state outputs
    d_rst = 1; step(); step();
    chk("rst_pred_valid", 32'(pred_valid_o), 0);
    chk("rst_pred_hit", 32'(pred_hit_o), 0);
    chk("rst_pred_taken", 32'(pred_taken_o), 0);
    chk("rst_pred_pc", pred_pc_o, 0);
    chk("rst_pred_ghr", 32'(pred_ghr_o), 0);
    chk("rst_busy", 32'(busy_o), 1);

    // Clear length after reset release
    idle();
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy_o !== 1'b1) break;
      busy_cnt++;
    end
    chk("clear_len_after_reset", 32'(busy_cnt), ENTRIES);

    // Lookup on an empty table
    do_lookup(32'h100);
    // Allocate taken branch, then look it up
    do_resolve(32'h100, 32'h200, 1, 1, 0, 32'h0, m_ghr);
    chk("alloc_mispredict", 32'(mispredict_o), 1);
    do_lookup(32'h100);
    // Train down to saturation with the history seen at allocation
    for (int i = 0; i < 3; i++) do_resolve(32'h100, 32'h200, 1, 0, 1, 32'h200, 0);
    do_lookup(32'h100);
    // Aliasing: same index, different tag
    do_lookup(32'h140);
    // Non-branch predicted taken invalidates the entry
    do_resolve(32'h100, 32'h104, 0, 0, 1, 32'h200, m_ghr);
    chk("nonbranch_mispredict", 32'(mispredict_o), 1);
    do_lookup(32'h100);
    do_lookup(32'h100);

    // Randomized traffic, with occasional flushes
    for (int n = 0; n < 1500; n++) begin
      idle();
      d_flush = ($urandom_range(0, 299) == 0);
      d_lv = $urandom_range(0, 1);
      d_pc = rand_pc();
      d_rv = ($urandom_range(0, 3) != 0);
      d_rpc = rand_pc();
      d_rtgt = rand_tgt();
      d_isb = ($urandom_range(0, 4) != 0);
      d_tk = $urandom_range(0, 1);
      d_pt = $urandom_range(0, 1);
      d_ppc = $urandom_range(0, 1) ? m_tgt[idx_of(d_rpc)] : rand_tgt();
      d_rghr = $urandom_range(0, 1) ? m_ghr : int'($urandom_range(0, 15));
      step();
    end

    // Flush mid-CLEAR at index 7, with resolves and lookups during the clear
    idle(); d_rst = 1; step();
    idle();
    for (int i = 0; i < 7; i++) step();
    d_flush = 1; step(); idle();
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      d_rv = 1; d_rpc = 32'h100; d_rtgt = 32'h300; d_isb = 1; d_tk = 1; d_pt = 0; d_ppc = 0;
      d_lv = 1; d_pc = 32'h100; d_rghr = 0;
      step();
      if (busy_o !== 1'b1) break;
      busy_cnt++;
    end
    chk("clear_len_after_flush", 32'(busy_cnt), ENTRIES);
    do_lookup(32'h100);
    do_lookup(32'h100);
    idle(); step(); step();
    chk("scoreboard_drained", 32'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
